// File: rtl/operand_input_fsm_pkg.sv
// Shared definitions for the operand entry block: default parameters,
// the FSM state encoding and a helper that maps a state to its operand index.
package operand_input_fsm_pkg;

  localparam int unsigned DEBOUNCE_TICKS_DEF = 32;
  localparam int unsigned DATA_W_DEF         = 4;
  localparam int unsigned IDX_W              = 2;
  localparam int unsigned NUM_OPS            = 4;

  typedef enum logic [2:0] {
    GET_A = 3'd0,
    GET_B = 3'd1,
    GET_C = 3'd2,
    GET_D = 3'd3,
    SEND  = 3'd4,
    SHOW  = 3'd5
  } state_e;

  // Operand slot being entered; SEND and SHOW report slot 0.
  function automatic logic [IDX_W-1:0] state_index(input state_e s);
    case (s)
      GET_A:   return IDX_W'(0);
      GET_B:   return IDX_W'(1);
      GET_C:   return IDX_W'(2);
      GET_D:   return IDX_W'(3);
      default: return IDX_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/operand_input_fsm_if.sv
// Operand handshake towards the divider core.
//   op_valid_out      : operand set valid (master drives)
//   op_ready_in       : core ready to take the set (slave drives)
//   op_a..op_d_out    : captured operands (master drives)
interface operand_input_fsm_if
  import operand_input_fsm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              op_valid_out;
  logic              op_ready_in;
  logic [DATA_W-1:0] op_a_out;
  logic [DATA_W-1:0] op_b_out;
  logic [DATA_W-1:0] op_c_out;
  logic [DATA_W-1:0] op_d_out;

  modport master (
    output op_valid_out, op_a_out, op_b_out, op_c_out, op_d_out,
    input  op_ready_in
  );

  modport slave (
    input  op_valid_out, op_a_out, op_b_out, op_c_out, op_d_out,
    output op_ready_in
  );

endinterface

// File: rtl/operand_input_fsm_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter and a
// one-cycle press pulse on each accepted 0->1 of the debounced level.
//   clk, rst : clock, async active-high reset
//   btn_i    : raw asynchronous button
//   press_o  : one-cycle press pulse (releases produce nothing)
module operand_input_fsm_btn_debounce
  import operand_input_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; the last one flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/operand_input_fsm.sv
// Operand entry FSM: four button presses capture operands a..d from the
// switches, the set is offered to the divider over a valid/ready handshake,
// then the result is shown until a further press clears everything.
//   clk, rst          : clock, async active-high reset
//   btn_c_in          : raw centre button
//   sw_in             : operand switches
//   op_if (master)    : operand set + valid/ready handshake
//   disp_operand_out  : last captured operand
//   op_index_out      : next operand slot (0=a..3=d)
//   show_result_out   : result display phase
//   clear_out         : one-cycle downstream clear pulse
module operand_input_fsm
  import operand_input_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_c_in,
  input  logic [DATA_W-1:0]    sw_in,
  operand_input_fsm_if.master  op_if,
  output logic [DATA_W-1:0]    disp_operand_out,
  output logic [IDX_W-1:0]     op_index_out,
  output logic                 show_result_out,
  output logic                 clear_out
);

  logic              press;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_q [NUM_OPS];
  logic [DATA_W-1:0] op_d [NUM_OPS];
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              show_q, show_d;
  logic              clear_q, clear_d;

  operand_input_fsm_btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_c_in),
    .press_o(press)
  );

  // Next state and next register values; outputs follow the next state so
  // they line up with the state register.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    disp_d  = disp_q;
    clear_d = 1'b0;
    unique case (state_q)
      GET_A, GET_B, GET_C, GET_D: begin
        if (press) begin
          op_d[state_index(state_q)] = sw_in;
          disp_d                     = sw_in;
          unique case (state_q)
            GET_A:   state_d = GET_B;
            GET_B:   state_d = GET_C;
            GET_C:   state_d = GET_D;
            default: state_d = SEND;
          endcase
        end
      end
      SEND: begin
        // Presses are dropped here; only the handshake moves on.
        if (op_if.op_ready_in) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          clear_d = 1'b1;
          disp_d  = '0;
          for (int i = 0; i < int'(NUM_OPS); i++) begin
            op_d[i] = '0;
          end
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
    valid_d = (state_d == SEND);
    show_d  = (state_d == SHOW);
    idx_d   = state_index(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      for (int i = 0; i < int'(NUM_OPS); i++) begin
        op_q[i] <= '0;
      end
      disp_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      show_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      show_q  <= show_d;
      clear_q <= clear_d;
    end
  end

  assign op_if.op_valid_out = valid_q;
  assign op_if.op_a_out     = op_q[0];
  assign op_if.op_b_out     = op_q[1];
  assign op_if.op_c_out     = op_q[2];
  assign op_if.op_d_out     = op_q[3];
  assign disp_operand_out   = disp_q;
  assign op_index_out       = idx_q;
  assign show_result_out    = show_q;
  assign clear_out          = clear_q;

endmodule

// File: tb/tb_operand_input_fsm.sv
// Bench for operand_input_fsm: a table of button actions with expected
// outputs, hand sequences for handshake/reset corners, then random actions
// checked against a phase/operand model.
module tb_operand_input_fsm;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic [DW-1:0] sw  = '0;
  logic [DW-1:0] disp;
  logic [1:0]    idx;
  logic          show;
  logic          clr;

  operand_input_fsm_if #(.DATA_W(DW)) op_if ();

  operand_input_fsm #(.DEBOUNCE_TICKS(32), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_c_in        (btn),
    .sw_in           (sw),
    .op_if           (op_if),
    .disp_operand_out(disp),
    .op_index_out    (idx),
    .show_result_out (show),
    .clear_out       (clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int clr_cycles  = 0;

  always @(posedge clk) if (clr === 1'b1) clr_cycles <= clr_cycles + 1;

  // Model: phase 0..3 entering operand, 4 waiting for handshake, 5 showing.
  int            m_phase = 0;
  logic [DW-1:0] m_ops [4];
  logic [DW-1:0] m_disp = '0;
  int            m_clears = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_disp  = '0;
    for (int i = 0; i < 4; i++) m_ops[i] = '0;
  endtask

  task automatic model_press(input logic [DW-1:0] v);
    if (m_phase < 4) begin
      m_ops[m_phase] = v;
      m_disp = v;
      m_phase++;
    end else if (m_phase == 5) begin
      model_reset();
      m_clears++;
    end
  endtask

  task automatic check_all();
    chk("op_index", 32'(idx), (m_phase < 4) ? 32'(m_phase) : 32'd0);
    chk("op_valid", 32'(op_if.op_valid_out), 32'(m_phase == 4));
    chk("show_result", 32'(show), 32'(m_phase == 5));
    chk("disp", 32'(disp), 32'(m_disp));
    chk("op_a", 32'(op_if.op_a_out), 32'(m_ops[0]));
    chk("op_b", 32'(op_if.op_b_out), 32'(m_ops[1]));
    chk("op_c", 32'(op_if.op_c_out), 32'(m_ops[2]));
    chk("op_d", 32'(op_if.op_d_out), 32'(m_ops[3]));
    chk("clear_pulses", 32'(clr_cycles), 32'(m_clears));
  endtask

  // Hold the button 34 cycles then release long enough to debounce low.
  task automatic do_press(input logic [DW-1:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    repeat (34) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    model_press(v);
  endtask

  // 20-cycle pulse followed by a train of 5-cycle bounces: never accepted.
  task automatic do_glitch();
    @(negedge clk);
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      repeat (5) @(negedge clk);
      btn = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (40) @(negedge clk);
  endtask

  // Ready withheld for 50 cycles (valid/operands must hold), then one ready edge.
  task automatic do_handshake();
    @(negedge clk);
    op_if.op_ready_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_phase == 4) begin
        chk("valid_hold", 32'(op_if.op_valid_out), 32'd1);
        chk("op_d_hold", 32'(op_if.op_d_out), 32'(m_ops[3]));
      end
    end
    op_if.op_ready_in = 1'b1;
    @(posedge clk);
    #1;
    op_if.op_ready_in = 1'b0;
    if (m_phase == 4) m_phase = 5;
    chk("show_after_ready", 32'(show), 32'(m_phase == 5));
    chk("valid_after_ready", 32'(op_if.op_valid_out), 32'(m_phase == 4));
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(op_if.op_valid_out), 32'd0);
    chk({tag, "_ops"}, 32'({op_if.op_a_out, op_if.op_b_out, op_if.op_c_out, op_if.op_d_out}), 32'd0);
    chk({tag, "_disp"}, 32'(disp), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_show"}, 32'(show), 32'd0);
    chk({tag, "_clr"}, 32'(clr), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int            act;       // 0 press, 1 handshake, 2 glitch
    logic [DW-1:0] sw;
    int            exp_idx;
    bit            exp_valid;
    bit            exp_show;
    logic [DW-1:0] exp_disp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    op_if.op_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) m_ops[i] = '0;

    tbl[0] = '{0, 4'd3, 1, 1'b0, 1'b0, 4'd3};
    tbl[1] = '{0, 4'd0, 2, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{0, 4'd2, 3, 1'b0, 1'b0, 4'd2};
    tbl[3] = '{0, 4'd1, 0, 1'b1, 1'b0, 4'd1};
    tbl[4] = '{0, 4'd5, 0, 1'b1, 1'b0, 4'd1};  // ignored in SEND
    tbl[5] = '{1, 4'd0, 0, 1'b0, 1'b1, 4'd1};
    tbl[6] = '{0, 4'd7, 0, 1'b0, 1'b0, 4'd0};  // clear from SHOW
    tbl[7] = '{2, 4'd0, 0, 1'b0, 1'b0, 4'd0};
    tbl[8] = '{0, 4'b1000, 1, 1'b0, 1'b0, 4'b1000};

    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    for (int i = 0; i < 9; i++) begin
      case (tbl[i].act)
        0:       do_press(tbl[i].sw);
        1:       do_handshake();
        default: do_glitch();
      endcase
      chk("tbl_idx", 32'(idx), 32'(tbl[i].exp_idx));
      chk("tbl_valid", 32'(op_if.op_valid_out), 32'(tbl[i].exp_valid));
      chk("tbl_show", 32'(show), 32'(tbl[i].exp_show));
      chk("tbl_disp", 32'(disp), 32'(tbl[i].exp_disp));
      check_all();
      if (i == 3) begin
        chk("seq_a", 32'(op_if.op_a_out), 32'd3);
        chk("seq_b", 32'(op_if.op_b_out), 32'd0);
        chk("seq_c", 32'(op_if.op_c_out), 32'd2);
        chk("seq_d", 32'(op_if.op_d_out), 32'd1);
      end
      if (i == 6) chk("clear_once", 32'(clr_cycles), 32'd1);
      if (i == 8) chk("neg8_bits", 32'(op_if.op_a_out), 32'h8);
    end

    // Reset in GET_C with a=8, b=2.
    do_press(4'd2);
    check_all();
    async_reset_check("rst_getc");

    // Reset while the handshake is pending: valid drops, no clear pulse.
    do_press(4'd9);
    do_press(4'd4);
    do_press(4'd15);
    do_press(4'd6);
    chk("send_valid", 32'(op_if.op_valid_out), 32'd1);
    async_reset_check("rst_send");

    for (int n = 0; n < 30; n++) begin
      int a;
      a = int'($urandom_range(0, 5));
      case (a)
        0, 1, 2: do_press(DW'($urandom_range(0, 15)));
        3:       do_handshake();
        4:       do_glitch();
        default: async_reset_check("rst_rand");
      endcase
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
